lsu_mem_stage: RTL and testbench

//  MEM-stage load/store unit of the RV32I pipeline. Takes EX/MEM load/store requests and drives the

---
 rtl/lsu_mem_stage.sv | 260 ++++++++++++++++++++++++++
 tb/tb_lsu_mem_stage.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_stage.sv
// -----------------------------------------------------------------------------
// lsu_mem_stage
//   MEM-stage load/store unit for an RV32I pipeline. It accepts one load or
//   store from EX/MEM and runs it on the data memory through a req/gnt/rvalid
//   handshake. The pipeline is stalled until the access completes.
//   For stores it generates byte enables and lane-replicated data. For loads
//   it sign- or zero-extends the returned data. It also exports the
//   memwrite/dataadr/writedata observation signals.
//
//   Optional feature macro: LSU_MISALIGN_TRAP_EN
//     defined   : misaligned LH/LHU/SH/LW/SW finish with rsp_err and make no
//                 memory access
//     undefined : the low address bits are forced to alignment and the
//                 access proceeds
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   req_valid/load/store/funct3  EX/MEM request qualifiers
//   req_addr, req_wdata          byte address and raw rs2 value
//   stall_o                      freezes IF..EX/MEM while the access runs
//   rsp_valid/rdata/err          one-cycle completion with extended load data
//   mem_req/we/be/addr/wdata     data-memory request, held stable until gnt
//   mem_gnt/rvalid/rdata         data-memory grant and read response
//   memwrite/dataadr/writedata   observation: store grant pulse, captured
//                                address and captured rs2 value
// -----------------------------------------------------------------------------
module lsu_mem_stage #(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_load,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall_o,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        memwrite,
  output logic [31:0] dataadr,
  output logic [31:0] writedata
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic               load_q, load_d;
  logic [2:0]         f3_q, f3_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               err_q, err_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               legal_s;
  logic               timeout_s;
  logic [1:0]         off_s;

  // Accepted funct3 codes differ between loads and stores.
  function automatic logic f3_legal(input logic is_load, input logic [2:0] f3);
    logic ok;
    if (is_load) begin
      case (f3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: ok = 1'b1;
        default:                                ok = 1'b0;
      endcase
    end else begin
      case (f3)
        3'b000, 3'b001, 3'b010: ok = 1'b1;
        default:                ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

  // Only used when the misalignment trap is built in.
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
    logic mis;
    case (f3[1:0])
      2'b01:   mis = a[0];
      2'b10:   mis = (a != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

  // Byte lane of the access. Half and word accesses ignore the low bits, so
  // misaligned addresses fall back to the aligned lane.
  function automatic logic [1:0] lane_off(input logic [2:0] f3, input logic [1:0] a);
    logic [1:0] off;
    case (f3[1:0])
      2'b00:   off = a;
      2'b01:   off = {a[1], 1'b0};
      default: off = 2'b00;
    endcase
    return off;
  endfunction

  // Byte enables for the access width at the given lane.
  function automatic logic [3:0] access_be(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] be;
    case (f3[1:0])
      2'b00:   be = 4'b0001 << off;
      2'b01:   be = 4'b0011 << off;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Store data is replicated across all lanes. The byte enables select the
  // lanes that are actually written.
  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] w;
    case (f3[1:0])
      2'b00:   w = {4{d[7:0]}};
      2'b01:   w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

  // Shift the addressed lane down to bit 0, then extend it by funct3.
  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [31:0] word,
                                           input logic [1:0] off);
    logic [31:0] s;
    logic [31:0] r;
    s = word >> {off, 3'b000};
    case (f3)
      3'b000:  r = {{24{s[7]}}, s[7:0]};
      3'b001:  r = {{16{s[15]}}, s[15:0]};
      3'b100:  r = {24'h000000, s[7:0]};
      3'b101:  r = {16'h0000, s[15:0]};
      default: r = s;
    endcase
    return r;
  endfunction

  // State register and captured request fields.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      load_q  <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= 32'h0000_0000;
      wdata_q <= 32'h0000_0000;
      err_q   <= 1'b0;
      rdata_q <= 32'h0000_0000;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      load_q  <= load_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: capture, handshake progress and timeout abort.
  always_comb begin
    state_d   = state_q;
    load_d    = load_q;
    f3_d      = f3_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    err_d     = err_q;
    rdata_d   = rdata_q;
    cnt_d     = cnt_q;
    legal_s   = f3_legal(req_load, req_funct3);
`ifdef LSU_MISALIGN_TRAP_EN
    legal_s   = legal_s & ~misaligned(req_funct3, req_addr[1:0]);
`endif
    // The REQ and WAIT cycles share one budget. An access still open in the
    // last budgeted cycle is aborted.
    timeout_s = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
    off_s     = lane_off(f3_q, addr_q[1:0]);
    case (state_q)
      ST_IDLE: begin
        if (req_valid && (req_load || req_store)) begin
          load_d  = req_load;
          f3_d    = req_funct3;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          rdata_d = 32'h0000_0000;
          cnt_d   = '0;
          err_d   = ~legal_s;
          state_d = legal_s ? ST_REQ : ST_DONE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (mem_gnt) begin
          state_d = load_q ? ST_WAIT : ST_DONE;
        end else if (timeout_s) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (mem_rvalid) begin
          rdata_d = load_ext(f3_q, mem_rdata, off_s);
          state_d = ST_DONE;
        end else if (timeout_s) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Memory, pipeline and observation outputs decoded from the state.
  always_comb begin
    stall_o   = ((state_q == ST_IDLE) && req_valid && (req_load || req_store)) ||
                (state_q == ST_REQ) || (state_q == ST_WAIT);
    mem_req   = (state_q == ST_REQ);
    mem_we    = mem_req && !load_q;
    mem_be    = mem_req ? access_be(f3_q, off_s) : 4'b0000;
    mem_addr  = mem_req ? {addr_q[31:2], 2'b00} : 32'h0000_0000;
    mem_wdata = mem_we ? store_data(f3_q, wdata_q) : 32'h0000_0000;
    memwrite  = mem_req && mem_we && mem_gnt;
    rsp_valid = (state_q == ST_DONE);
    rsp_err   = rsp_valid && err_q;
    rsp_rdata = rsp_valid ? rdata_q : 32'h0000_0000;
    dataadr   = addr_q;
    writedata = wdata_q;
  end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Testbench for lsu_mem_stage. A small memory model answers the data port.
// Each request pushes its expected response to a scoreboard queue, and a
// monitor pops and compares every rsp_valid pulse.
module tb_lsu_mem_stage;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_load;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall_o;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        memwrite;
  logic [31:0] dataadr;
  logic [31:0] writedata;

  int n_cmp = 0;
  int n_mis = 0;
  int cyc   = 0;

  logic gnt_en    = 1'b1;
  int   rv_dly    = 1;
  logic inject_rv = 1'b0;

  typedef struct {
    int          drv_cyc;
    int          lat;
    logic [31:0] rdata;
    logic        err;
    logic [3:0]  be;
    logic [31:0] mwdata;
    int          nreq;
    int          nwr;
    logic [31:0] addr;
    logic [31:0] raw;
  } exp_t;

  exp_t sb_q[$];

  int          nreq_obs = 0;
  int          nwr_obs  = 0;
  logic [3:0]  be_obs   = 4'b0000;
  logic [31:0] wd_obs   = 32'h0;

  lsu_mem_stage #(.TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_load(req_load), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .stall_o(stall_o), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata)
  );

  assign mem_gnt = mem_req & gnt_en;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Memory model: a write is applied in its grant cycle. A read returns
  // rv_dly cycles after its grant.
  initial begin
    logic [31:0] mem_m [logic [29:0]];
    int          rv_cnt;
    logic [31:0] rv_data;
    logic        rv;
    logic [31:0] w;
    rv_cnt  = 0;
    rv_data = 32'h0;
    mem_m[30'(32'h100 >> 2)] = 32'h1234_ABCD;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
    forever begin
      @(negedge clk);
      rv = 1'b0;
      if (rv_cnt > 0) begin
        rv_cnt--;
        if (rv_cnt == 0) rv = 1'b1;
      end
      if (mem_req && mem_gnt && !rst) begin
        w = mem_m.exists(mem_addr[31:2]) ? mem_m[mem_addr[31:2]] : 32'h0;
        if (mem_we) begin
          for (int b = 0; b < 4; b++)
            if (mem_be[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
          mem_m[mem_addr[31:2]] = w;
        end else begin
          rv_cnt  = rv_dly;
          rv_data = w;
        end
      end
      mem_rvalid = rv | inject_rv;
      mem_rdata  = rv ? rv_data : 32'hDEAD_BEEF;
    end
  end

  // Monitor: tally the memory activity of the current access and check each
  // completion against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      nreq_obs = 0;
      nwr_obs  = 0;
    end else begin
      if (mem_req) nreq_obs++;
      if (memwrite) begin
        nwr_obs++;
        be_obs = mem_be;
        wd_obs = mem_wdata;
      end
      if (rsp_valid) begin
        if (sb_q.size() == 0) begin
          check_eq("spurious_rsp", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          check_eq("latency", 32'(cyc - e.drv_cyc), 32'(e.lat));
          check_eq("rdata", rsp_rdata, e.rdata);
          check_eq("err", {31'd0, rsp_err}, {31'd0, e.err});
          check_eq("stall_done", {31'd0, stall_o}, 32'd0);
          check_eq("nreq", 32'(nreq_obs), 32'(e.nreq));
          check_eq("nwrite", 32'(nwr_obs), 32'(e.nwr));
          check_eq("dataadr", dataadr, e.addr);
          check_eq("writedata", writedata, e.raw);
          if (e.nwr > 0) begin
            check_eq("mem_be", {28'd0, be_obs}, {28'd0, e.be});
            check_eq("mem_wdata", wd_obs, e.mwdata);
          end
        end
        nreq_obs = 0;
        nwr_obs  = 0;
      end
    end
  end

  // Issue one request, push its expectation, and wait (bounded) for it to retire.
  task automatic issue(input logic ld, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input int lat, input logic [31:0] rd,
                       input logic er, input logic [3:0] be, input logic [31:0] mwd,
                       input int nreq, input int nwr);
    exp_t e;
    e.drv_cyc = cyc; e.lat = lat; e.rdata = rd; e.err = er; e.be = be;
    e.mwdata = mwd; e.nreq = nreq; e.nwr = nwr; e.addr = a; e.raw = wd;
    sb_q.push_back(e);
    req_valid  = 1'b1;
    req_load   = ld;
    req_store  = !ld;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    #1;
    check_eq("stall_accept", {31'd0, stall_o}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int i = 0; i < 40 && sb_q.size() != 0; i++) @(posedge clk);
    #1;
    if (sb_q.size() != 0) begin
      check_eq("rsp_timeout", 32'(sb_q.size()), 32'd0);
      sb_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_load = 1'b0; req_store = 1'b0;
    req_funct3 = 3'b000; req_addr = 32'h0; req_wdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_eq("rst_stall", {31'd0, stall_o}, 32'd0);
    check_eq("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check_eq("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check_eq("rst_dataadr", dataadr, 32'h0);
    check_eq("rst_writedata", writedata, 32'h0);
    @(posedge clk); #1;

    // Stores and loads from the reference table.
    issue(1'b0, 3'b010, 32'h400, 32'h1234_ABCD, 2, 32'h0, 1'b0, 4'b1111, 32'h1234_ABCD, 1, 1);
    issue(1'b1, 3'b000, 32'h100, 32'h0, 3, 32'hFFFF_FFCD, 1'b0, 4'b0, 32'h0, 1, 0);
    issue(1'b1, 3'b100, 32'h100, 32'h0, 3, 32'h0000_00CD, 1'b0, 4'b0, 32'h0, 1, 0);
    issue(1'b1, 3'b001, 32'h100, 32'h0, 3, 32'hFFFF_ABCD, 1'b0, 4'b0, 32'h0, 1, 0);
    issue(1'b1, 3'b101, 32'h100, 32'h0, 3, 32'h0000_ABCD, 1'b0, 4'b0, 32'h0, 1, 0);
    issue(1'b1, 3'b001, 32'h102, 32'h0, 3, 32'h0000_1234, 1'b0, 4'b0, 32'h0, 1, 0);
    issue(1'b1, 3'b010, 32'h100, 32'h0, 3, 32'h1234_ABCD, 1'b0, 4'b0, 32'h0, 1, 0);
    issue(1'b1, 3'b000, 32'h103, 32'h0, 3, 32'h0000_0012, 1'b0, 4'b0, 32'h0, 1, 0);
    issue(1'b1, 3'b100, 32'h102, 32'h0, 3, 32'h0000_0034, 1'b0, 4'b0, 32'h0, 1, 0);
    issue(1'b0, 3'b000, 32'h401, 32'h0000_00CD, 2, 32'h0, 1'b0, 4'b0010, 32'hCDCD_CDCD, 1, 1);
    issue(1'b0, 3'b001, 32'h402, 32'h0000_1234, 2, 32'h0, 1'b0, 4'b1100, 32'h1234_1234, 1, 1);
    issue(1'b1, 3'b010, 32'h400, 32'h0, 3, 32'h1234_CDCD, 1'b0, 4'b0, 32'h0, 1, 0);

    // Illegal funct3: immediate error, no memory access.
    issue(1'b1, 3'b011, 32'h100, 32'h0, 1, 32'h0, 1'b1, 4'b0, 32'h0, 0, 0);
    issue(1'b0, 3'b011, 32'h404, 32'h5555_AAAA, 1, 32'h0, 1'b1, 4'b0, 32'h0, 0, 0);

    // Misaligned word load.
`ifdef LSU_MISALIGN_TRAP_EN
    issue(1'b1, 3'b010, 32'h101, 32'h0, 1, 32'h0, 1'b1, 4'b0, 32'h0, 0, 0);
`else
    issue(1'b1, 3'b010, 32'h101, 32'h0, 3, 32'h1234_ABCD, 1'b0, 4'b0, 32'h0, 1, 0);
`endif

    // Grant withheld: 16 request cycles, then an error completion.
    gnt_en = 1'b0;
    issue(1'b1, 3'b010, 32'h100, 32'h0, 17, 32'h0, 1'b1, 4'b0, 32'h0, 16, 0);
    gnt_en = 1'b1;
    check_eq("to_mem_req_drop", {31'd0, mem_req}, 32'd0);
    inject_rv = 1'b1;
    @(posedge clk); #1;
    inject_rv = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("late_rv_stall", {31'd0, stall_o}, 32'd0);

    // Reset while waiting for read data.
    rv_dly = 3;
    req_valid = 1'b1; req_load = 1'b1; req_store = 1'b0;
    req_funct3 = 3'b010; req_addr = 32'h100;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    check_eq("wait_stall", {31'd0, stall_o}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq("rst_mid_stall", {31'd0, stall_o}, 32'd0);
    check_eq("rst_mid_mem_req", {31'd0, mem_req}, 32'd0);
    check_eq("rst_mid_rsp", {31'd0, rsp_valid}, 32'd0);
    repeat (6) @(posedge clk);
    #1;
    rv_dly = 1;
    issue(1'b1, 3'b010, 32'h100, 32'h0, 3, 32'h1234_ABCD, 1'b0, 4'b0, 32'h0, 1, 0);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
